// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the operand-RAM read sequencer.
// State codes are kept as fixed localparams so the encoding matches older netlists.
package ram_rd_pkg;

  localparam int RD_DEPTH = 10;
  localparam int RD_AW    = 6;
  localparam int RD_DW    = 16;

  localparam logic [15:0] RD_CLEAR_DATA = 16'h0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FIN    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    FIN    = ST_FIN
  } rd_state_e;

  // A request is serviceable only if it names 1..depth words starting inside the RAM.
  function automatic logic rd_req_ok(input int base, input int len, input int depth);
    return (len != 0) && (len <= depth) && (base < depth);
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM port plus outbound valid/ready stream of the read sequencer.
// master = sequencer side, slave = RAM/datapath side.
interface ram_stream_reader_if
  import ram_rd_pkg::*;
#(
  parameter int AW = RD_AW,
  parameter int DW = RD_DW
);

  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output mem_a, mem_we, mem_di, m_valid, m_data, m_last,
    input  mem_do, m_ready
  );

  modport slave (
    input  mem_a, mem_we, mem_di, m_valid, m_data, m_last,
    output mem_do, m_ready
  );

endinterface

// File: rtl/ram_rd_addr_ctr.sv
// Loadable address counter wrapping at DEPTH-1 (non power-of-2), plus a
// remaining-word down-counter whose last flag marks the final beat.
module ram_rd_addr_ctr
  import ram_rd_pkg::*;
#(
  parameter int DEPTH = RD_DEPTH,
  parameter int AW    = RD_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_len,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_len;
    end else if (i_step) begin
      r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
      r_rem  <= r_rem - AW'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == AW'(1));

endmodule

// File: rtl/ram_stream_reader.sv
// Drains a programmed window of the operand RAM as a valid/ready stream.
// Optional clear-on-read behind each consumed word: define RAM_RD_CLEAR_ON_READ_EN.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int DEPTH = RD_DEPTH,
  parameter int AW    = RD_AW,
  parameter int DW    = RD_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       len,
  output logic                busy,
  output logic                done,
  output logic                err,
  ram_stream_reader_if.master bus
);

  rd_state_e     r_state;
  logic          r_err;
  logic          w_req_ok;
  logic          w_load;
  logic          w_valid;
  logic          w_hs;
  logic          w_last;
  logic [AW-1:0] w_addr;

  assign w_req_ok = rd_req_ok(32'(base_addr), 32'(len), DEPTH);
  assign w_load   = (r_state == IDLE) && start && w_req_ok;
  assign w_valid  = (r_state == STREAM);
  assign w_hs     = w_valid && bus.m_ready;

  ram_rd_addr_ctr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_hs),
    .i_base (base_addr),
    .i_len  (len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= w_req_ok ? STREAM : FIN;
            r_err   <= !w_req_ok;
          end
        end
        STREAM: begin
          if (w_hs && w_last) begin
            r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FIN);
  assign err  = done && r_err;

  assign bus.m_valid = w_valid;
  assign bus.m_last  = w_valid && w_last;
  assign bus.m_data  = w_valid ? bus.mem_do : '0;
  assign bus.mem_a   = w_addr;
  assign bus.mem_di  = DW'(RD_CLEAR_DATA);

`ifdef RAM_RD_CLEAR_ON_READ_EN
  // Gated by rst so a reset landing on a handshake edge leaves the entry intact.
  assign bus.mem_we = w_hs && !rst;
`else
  assign bus.mem_we = 1'b0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a behavioural RAM and an
// address-window reference model (expected beats = ram[(base+i) mod DEPTH]).
module tb_ram_stream_reader;

  localparam int DEPTH = 10;
  localparam int AW    = 6;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, err;

  always #5 clk = ~clk;

  ram_stream_reader_if #(.AW(AW), .DW(DW)) bus ();

  ram_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  logic [15:0] ram [0:15];
  logic        preload_req = 1'b0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) ram[i] <= 16'h1000 + 16'(i);
    end else if (bus.mem_we && bus.mem_a < AW'(16)) begin
      ram[bus.mem_a[3:0]] <= bus.mem_di;
    end
  end

  assign bus.mem_do = (bus.mem_a < AW'(DEPTH)) ? ram[bus.mem_a[3:0]] : 16'hDEAD;

  logic [15:0] ref_ram [0:DEPTH-1];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic preload();
    @(negedge clk);
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_ram[i] = 16'h1000 + 16'(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_err"},     err, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_last"},  bus.m_last, 0);
    check({tag, "_mem_we"},  bus.mem_we, 0);
    check({tag, "_mem_a"},   bus.mem_a, 0);
    check({tag, "_mem_di"},  bus.mem_di, 0);
  endtask

  // One transfer; pct<0 selects the explicit per-cycle ready pattern.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] n, input int pct,
                          input logic [63:0] pat, input bit poke,
                          output logic [15:0] first, output int nbeats);
    bit          exp_err;
    logic [15:0] exp_q[$];
    int          addr_q[$];
    int          used_q[$];
    int          hs_cyc;
    bit          got_done;
    bit          stalled;
    bit          rdy;
    logic [15:0] hold_d;
    logic [AW-1:0] hold_a;
    logic        hold_l;
    exp_err  = (n == 0) || (n > DEPTH) || (b >= DEPTH);
    hs_cyc   = -1;
    got_done = 0;
    stalled  = 0;
    first    = '0;
    nbeats   = 0;
    hold_d   = '0;
    hold_a   = '0;
    hold_l   = 0;
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        addr_q.push_back((int'(b) + i) % DEPTH);
        exp_q.push_back(ref_ram[(int'(b) + i) % DEPTH]);
      end
    end
    @(negedge clk);
    start = 1'b1; base_addr = b; len = n; bus.m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("valid_latency", bus.m_valid, !exp_err);
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      check("busy_high", busy, 1);
      if (stalled) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_data", bus.m_data, hold_d);
        check("hold_addr", bus.mem_a, hold_a);
        check("hold_last", bus.m_last, hold_l);
      end
      if (done) begin
        got_done = 1;
        check("done_time", cyc, hs_cyc + 1);
        check("err", err, exp_err);
        check("beats_left", exp_q.size(), 0);
        check("valid_in_fin", bus.m_valid, 0);
      end else begin
        check("err_low", err, 0);
        if (bus.m_valid) begin
          if (exp_q.size() == 0) begin
            fail("extra_beat", nbeats + 1, nbeats);
          end else begin
            check("beat_data", bus.m_data, exp_q[0]);
            check("beat_addr", bus.mem_a, addr_q[0]);
            check("beat_last", bus.m_last, exp_q.size() == 1);
          end
        end
        rdy = (pct < 0) ? pat[cyc] : ($urandom_range(99) < pct);
        bus.m_ready = rdy;
        if (poke && cyc == 1) begin
          start = 1'b1; base_addr = 6'd7; len = 6'd1;
        end else begin
          start = 1'b0;
        end
        stalled = bus.m_valid && !rdy;
        hold_d  = bus.m_data;
        hold_a  = bus.mem_a;
        hold_l  = bus.m_last;
        if (bus.m_valid && rdy) begin
          if (nbeats == 0) first = bus.m_data;
          nbeats++;
          hs_cyc = cyc;
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            used_q.push_back(addr_q.pop_front());
          end
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got_done) fail("done_timeout", 0, 1);
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_end", busy, 0);
`ifdef RAM_RD_CLEAR_ON_READ_EN
    foreach (used_q[k]) ref_ram[used_q[k]] = 16'h0000;
`endif
  endtask

  typedef struct {
    logic [AW-1:0] b;
    logic [AW-1:0] n;
    int            exp_beats;
    logic [15:0]   exp_first;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] first;
  int          nbeats;

  initial begin
    tbl[0] = '{6'd2,  6'd3,  3, 16'h1002};
    tbl[1] = '{6'd8,  6'd4,  4, 16'h1008};
    tbl[2] = '{6'd0,  6'd0,  0, 16'h0000};
    tbl[3] = '{6'd10, 6'd1,  0, 16'h0000};
    tbl[4] = '{6'd5,  6'd11, 0, 16'h0000};
    tbl[5] = '{6'd5,  6'd1,  1, 16'h1005};
    tbl[6] = '{6'd63, 6'd5,  0, 16'h0000};
    tbl[7] = '{6'd6,  6'd2,  2, 16'h1006};

    bus.m_ready = 1'b0;
    start = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    preload();

    foreach (tbl[i]) begin
      run_xfer(tbl[i].b, tbl[i].n, 100, '1, 0, first, nbeats);
      check("tbl_beats", nbeats, tbl[i].exp_beats);
      check("tbl_first", first, tbl[i].exp_first);
    end

    preload();
    run_xfer(6'd1, 6'd5, -1, 64'hFFFF_FFFF_FFFF_FFE3, 0, first, nbeats);
    check("bp_beats", nbeats, 5);
    run_xfer(6'd2, 6'd3, 100, '1, 1, first, nbeats);
    check("poke_beats", nbeats, 3);

    preload();
    @(negedge clk);
    start = 1'b1; base_addr = 6'd0; len = 6'd5; bus.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_beat0", bus.m_data, ref_ram[0]);
    @(negedge clk);
    check("rst_beat1", bus.m_data, ref_ram[1]);
    @(negedge clk);
    check("rst_beat2_valid", bus.m_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_m_data", bus.m_data, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
      check("midrst_idle", busy, 0);
    end
`ifdef RAM_RD_CLEAR_ON_READ_EN
    ref_ram[0] = 16'h0000;
    ref_ram[1] = 16'h0000;
`endif
    run_xfer(6'd0, 6'd5, 100, '1, 0, first, nbeats);
    check("after_rst_beats", nbeats, 5);

    for (int r = 0; r < 12; r++) begin
      logic [AW-1:0] rb, rn;
      rb = AW'($urandom_range(11));
      rn = AW'($urandom_range(11));
      run_xfer(rb, rn, int'($urandom_range(100, 30)), '1, 0, first, nbeats);
    end

    preload();
    run_xfer(6'd0, 6'd10, 100, '1, 0, first, nbeats);
    check("full_first", first, 16'h1000);
    run_xfer(6'd0, 6'd10, 70, '1, 0, first, nbeats);
    check("full_beats", nbeats, 10);
    for (int i = 0; i < DEPTH; i++) check("ram_final", ram[i], ref_ram[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
